// File: rtl/run_before_if.sv
// Handshake bundle between the bitstream source, the run_before decoder and
// the coefficient reconstruction stage.
//   bit_valid/bit_data/bit_ready  : serial codeword bits, one per handshake
//   run_valid/run_ready           : decoded run handshake
//   run_before/coeff_idx/bits_used: decoded run payload
// master = stream source / run consumer side; slave = decoder side.
interface run_before_if;
  logic       bit_valid;
  logic       bit_data;
  logic       bit_ready;
  logic       run_valid;
  logic       run_ready;
  logic [3:0] run_before;
  logic [3:0] coeff_idx;
  logic [3:0] bits_used;

  modport master (
    output bit_valid, bit_data, run_ready,
    input  bit_ready, run_valid, run_before, coeff_idx, bits_used
  );

  modport slave (
    input  bit_valid, bit_data, run_ready,
    output bit_ready, run_valid, run_before, coeff_idx, bits_used
  );
endinterface

// File: rtl/run_before_decoder.sv
// CAVLC run_before decoder. Takes codeword bits MSB-first and emits one
// run_before value per coefficient of the block, tracking zeros_left.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   start            : latch total_zeros/total_coeff (IDLE or ERR only)
//   total_zeros      : zeros before the last nonzero coefficient
//   total_coeff      : nonzero coefficients in the block
//   bus (slave)      : bit input handshake and run output handshake
//   done             : one-cycle pulse after the last run is accepted
//   error            : illegal stream, sticky until start or rst
//   busy             : high in any state except IDLE
module run_before_decoder #(
  parameter int unsigned MAX_CW_LEN = 11,
  parameter int unsigned COEFF_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         total_zeros,
  input  logic [COEFF_W-1:0] total_coeff,
  run_before_if.slave        bus,
  output logic               done,
  output logic               error,
  output logic               busy
);

  localparam int unsigned CW_W  = MAX_CW_LEN;
  localparam int unsigned LEN_W = 4;

  typedef enum logic [2:0] {IDLE, FETCH, EMIT, DONE, ERR} state_t;

  state_t           state;
  logic [3:0]       zl;
  logic [3:0]       idx;
  logic [3:0]       tc_last;
  logic [CW_W-1:0]  cw;
  logic [LEN_W-1:0] len;
  logic             bit_ready_q;
  logic             run_valid_q;
  logic [3:0]       run_q;
  logic [3:0]       bits_used_q;

  logic [CW_W-1:0]  cw_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic [2:0]       tbl;
  logic             hit;
  logic [3:0]       dec_run;
  logic [3:0]       zl_sub;

  assign bus.bit_ready  = bit_ready_q;
  assign bus.run_valid  = run_valid_q;
  assign bus.run_before = run_q;
  assign bus.coeff_idx  = idx;
  assign bus.bits_used  = bits_used_q;

  assign zl_sub = zl - run_q;

  // Codeword match on the codeword as it would look with the incoming bit.
  always_comb begin
    cw_nxt  = {cw[CW_W-2:0], bus.bit_data};
    len_nxt = len + LEN_W'(1);
    tbl     = (zl > 4'd6) ? 3'd7 : zl[2:0];
    hit     = 1'b0;
    dec_run = 4'd0;
    case (tbl)
      3'd1: if (len_nxt == 4'd1) begin
        hit = 1'b1; dec_run = cw_nxt[0] ? 4'd0 : 4'd1;
      end
      3'd2: if (len_nxt == 4'd1 && cw_nxt[0]) begin
        hit = 1'b1; dec_run = 4'd0;
      end else if (len_nxt == 4'd2) begin
        hit = 1'b1; dec_run = cw_nxt[0] ? 4'd1 : 4'd2;
      end
      3'd3: if (len_nxt == 4'd2) begin
        hit = 1'b1; dec_run = 4'd3 - {2'b00, cw_nxt[1:0]};
      end
      3'd4: if (len_nxt == 4'd2 && cw_nxt[1:0] != 2'b00) begin
        hit = 1'b1; dec_run = 4'd3 - {2'b00, cw_nxt[1:0]};
      end else if (len_nxt == 4'd3) begin
        hit = 1'b1; dec_run = 4'd4 - {3'b000, cw_nxt[0]};
      end
      3'd5: if (len_nxt == 4'd2 && cw_nxt[1]) begin
        hit = 1'b1; dec_run = 4'd3 - {2'b00, cw_nxt[1:0]};
      end else if (len_nxt == 4'd3) begin
        hit = 1'b1; dec_run = 4'd5 - {1'b0, cw_nxt[2:0]};
      end
      3'd6: if (len_nxt == 4'd2 && cw_nxt[1:0] == 2'b11) begin
        hit = 1'b1; dec_run = 4'd0;
      end else if (len_nxt == 4'd3) begin
        hit = 1'b1;
        case (cw_nxt[2:0])
          3'b000:  dec_run = 4'd1;
          3'b001:  dec_run = 4'd2;
          3'b011:  dec_run = 4'd3;
          3'b010:  dec_run = 4'd4;
          3'b101:  dec_run = 4'd5;
          3'b100:  dec_run = 4'd6;
          default: hit = 1'b0;
        endcase
      end
      3'd7: if (len_nxt == 4'd3 && cw_nxt[2:0] != 3'b000) begin
        hit = 1'b1; dec_run = 4'd7 - {1'b0, cw_nxt[2:0]};
      end else if (len_nxt >= 4'd4 && cw_nxt == CW_W'(1)) begin
        // leading-zero codes: 0001 -> 7, each extra zero adds one
        hit = 1'b1; dec_run = len_nxt + 4'd3;
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      zl          <= '0;
      idx         <= '0;
      tc_last     <= '0;
      cw          <= '0;
      len         <= '0;
      bit_ready_q <= 1'b0;
      run_valid_q <= 1'b0;
      run_q       <= '0;
      bits_used_q <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR: if (start) begin
          error   <= 1'b0;
          busy    <= 1'b1;
          zl      <= total_zeros;
          idx     <= '0;
          tc_last <= 4'(total_coeff - COEFF_W'(1));
          cw      <= '0;
          len     <= '0;
          if (total_zeros != 4'd0 && total_coeff > COEFF_W'(1)) begin
            state       <= FETCH;
            bit_ready_q <= 1'b1;
          end else begin
            // single coeff or no zeros: the only run is implied
            state       <= EMIT;
            run_valid_q <= 1'b1;
            run_q       <= total_zeros;
            bits_used_q <= '0;
          end
        end
        FETCH: if (bus.bit_valid) begin
          cw  <= cw_nxt;
          len <= len_nxt;
          if (hit) begin
            bit_ready_q <= 1'b0;
            if (dec_run > zl) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state       <= EMIT;
              run_valid_q <= 1'b1;
              run_q       <= dec_run;
              bits_used_q <= len_nxt;
            end
          end else if (len_nxt == LEN_W'(MAX_CW_LEN)) begin
            state       <= ERR;
            error       <= 1'b1;
            bit_ready_q <= 1'b0;
          end
        end
        EMIT: if (bus.run_ready) begin
          zl  <= zl_sub;
          cw  <= '0;
          len <= '0;
          if (idx == tc_last) begin
            state       <= DONE;
            run_valid_q <= 1'b0;
            done        <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
            if (zl_sub == 4'd0 || (idx + 4'd1) == tc_last) begin
              // implied run: last coeff takes all remaining zeros, else 0
              run_q       <= zl_sub;
              bits_used_q <= '0;
            end else begin
              state       <= FETCH;
              run_valid_q <= 1'b0;
              bit_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_before_decoder.sv
// Directed bench for run_before_decoder: expected runs are queued when a
// block is started and checked as the decoder hands each run over.
module tb_run_before_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] total_zeros = '0;
  logic [4:0] total_coeff = '0;
  logic       done, error, busy;

  run_before_if bus ();

  run_before_decoder dut (
    .clk(clk), .rst(rst), .start(start),
    .total_zeros(total_zeros), .total_coeff(total_coeff),
    .bus(bus), .done(done), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int run; int idx; int bits;} exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int taken = 0;
  int run_seen = 0;

  always @(posedge clk) begin
    if (bus.bit_valid === 1'b1 && bus.bit_ready === 1'b1) taken++;
    if (bus.run_valid === 1'b1) run_seen++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int run, input int idx, input int bits);
    exp_t e;
    e.run = run; e.idx = idx; e.bits = bits;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int tz, input int tc);
    @(negedge clk);
    start = 1'b1; total_zeros = 4'(tz); total_coeff = 5'(tc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    while (bus.bit_ready !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) chk("bit_ready_timeout", 16'd0, 16'd1);
    bus.bit_valid = 1'b1; bus.bit_data = b;
    @(negedge clk);
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0;
  endtask

  task automatic accept_run(input int hold);
    exp_t e;
    int n = 0;
    while (bus.run_valid !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) begin
      chk("run_valid_timeout", 16'd0, 16'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("unexpected_run", 16'd1, 16'd0);
      e.run = 0; e.idx = 0; e.bits = 0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_run_valid", 16'(bus.run_valid), 16'd1);
      chk("hold_run_before", 16'(bus.run_before), 16'(e.run));
      chk("hold_bit_ready", 16'(bus.bit_ready), 16'd0);
    end
    chk("run_before", 16'(bus.run_before), 16'(e.run));
    chk("coeff_idx", 16'(bus.coeff_idx), 16'(e.idx));
    chk("bits_used", 16'(bus.bits_used), 16'(e.bits));
    bus.run_ready = 1'b1;
    @(negedge clk);
    bus.run_ready = 1'b0;
  endtask

  task automatic check_done();
    chk("done_pulse", 16'(done), 16'd1);
    @(negedge clk);
    chk("done_clear", 16'(done), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    int base;
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.run_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bit_ready", 16'(bus.bit_ready), 16'd0);
    chk("rst_run_valid", 16'(bus.run_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_error", 16'(error), 16'd0);
    rst = 1'b0;

    // 1: tz=3 tc=4, bits 1,0 | 1 | 0,1, last run implied
    base = taken;
    push(1, 0, 2); push(0, 1, 1); push(1, 2, 2); push(1, 3, 0);
    do_start(3, 4);
    chk("t1_busy", 16'(busy), 16'd1);
    send_bit(1'b1); send_bit(1'b0); accept_run(0);
    send_bit(1'b1); accept_run(0);
    send_bit(1'b0); send_bit(1'b1); accept_run(0);
    accept_run(0);
    check_done();
    chk("t1_bits_taken", 16'(taken - base), 16'd5);

    // 2: tz=7 tc=3, 0001 -> 7, remaining runs implied 0
    base = taken;
    push(7, 0, 4); push(0, 1, 0); push(0, 2, 0);
    do_start(7, 3);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("t2_bit_ready_low", 16'(bus.bit_ready), 16'd0);
    accept_run(0); accept_run(0); accept_run(0);
    check_done();
    chk("t2_bits_taken", 16'(taken - base), 16'd4);

    // 3: tz=0 tc=5, five implied zero runs, no bits requested
    base = taken;
    for (int i = 0; i < 5; i++) push(0, i, 0);
    do_start(0, 5);
    chk("t3_bit_ready", 16'(bus.bit_ready), 16'd0);
    for (int i = 0; i < 5; i++) accept_run(0);
    check_done();
    chk("t3_bits_taken", 16'(taken - base), 16'd0);

    // 4: tz=7 tc=2, eleven zeros -> error, no run
    base = run_seen;
    do_start(7, 2);
    for (int i = 0; i < 11; i++) send_bit(1'b0);
    chk("t4_error", 16'(error), 16'd1);
    chk("t4_bit_ready", 16'(bus.bit_ready), 16'd0);
    repeat (3) @(negedge clk);
    chk("t4_error_sticky", 16'(error), 16'd1);
    chk("t4_no_run", 16'(run_seen - base), 16'd0);
    push(0, 0, 0);
    do_start(0, 1);
    chk("t4_error_cleared", 16'(error), 16'd0);
    accept_run(0);
    check_done();

    // 5: tz=2 tc=2, 01 -> 1 held under back-pressure, then implied 1
    push(1, 0, 2); push(1, 1, 0);
    do_start(2, 2);
    send_bit(1'b0); send_bit(1'b1);
    accept_run(3);
    accept_run(0);
    check_done();

    // 6: reset mid-FETCH, then a clean block
    do_start(5, 6);
    send_bit(1'b0); send_bit(1'b1);
    chk("t6_fetching", 16'(bus.bit_ready), 16'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_bit_ready", 16'(bus.bit_ready), 16'd0);
    chk("t6_rst_run_valid", 16'(bus.run_valid), 16'd0);
    chk("t6_rst_run_before", 16'(bus.run_before), 16'd0);
    chk("t6_rst_coeff_idx", 16'(bus.coeff_idx), 16'd0);
    chk("t6_rst_bits_used", 16'(bus.bits_used), 16'd0);
    chk("t6_rst_busy", 16'(busy), 16'd0);
    chk("t6_rst_done", 16'(done), 16'd0);
    rst = 1'b0;
    base = taken;
    push(1, 0, 1); push(0, 1, 0);
    do_start(1, 2);
    send_bit(1'b0);
    accept_run(0); accept_run(0);
    check_done();
    chk("t6_bits_taken", 16'(taken - base), 16'd1);

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
